// File: rtl/ro_sequencer_if.sv
// Control/status bundle between top-level control, the RO sequencer and the flow/pressure monitor.
interface ro_sequencer_if;
    logic       start;
    logic       stop;
    logic       clr_fault;
    logic [7:0] psi_now;
    logic [7:0] psi_set;
    logic [7:0] run_len;
    logic       fail_in;
    logic       pump_on;
    logic       ro_en;
    logic       valve_flush;
    logic       busy;
    logic       fault;
    logic [2:0] state;
    logic [1:0] retry_cnt;

    modport master (
        output start, stop, clr_fault, psi_now, psi_set, run_len, fail_in,
        input  pump_on, ro_en, valve_flush, busy, fault, state, retry_cnt
    );

    modport slave (
        input  start, stop, clr_fault, psi_now, psi_set, run_len, fail_in,
        output pump_on, ro_en, valve_flush, busy, fault, state, retry_cnt
    );
endinterface

// File: rtl/ro_sequencer.sv
// RO stage cycle controller: pump start-up, run window, flush and fault handling.
// Optional automatic fault retry through COOL is enabled by defining RO_SEQ_AUTO_RETRY_EN.
module ro_sequencer #(
    parameter int PRESS_CYC = 16,
    parameter int FLUSH_CYC = 8,
    parameter int COOL_CYC  = 32,
    parameter int MAX_RETRY = 3
) (
    input  logic          clk,
    input  logic          rst,
    ro_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRESS = 3'd1,
        RUN   = 3'd2,
        FLUSH = 3'd3,
        FAULT = 3'd4,
        COOL  = 3'd5
    } state_t;

    localparam logic [7:0] PRESS_LAST = 8'(PRESS_CYC - 1);
    localparam logic [7:0] FLUSH_LAST = 8'(FLUSH_CYC - 1);

    if (PRESS_CYC < 1 || PRESS_CYC > 255) begin : g_bad_press
        $error("PRESS_CYC out of range");
    end
    if (FLUSH_CYC < 2 || FLUSH_CYC > 255) begin : g_bad_flush
        $error("FLUSH_CYC out of range");
    end
    if (COOL_CYC < 1 || COOL_CYC > 255) begin : g_bad_cool
        $error("COOL_CYC out of range");
    end
    if (MAX_RETRY < 0 || MAX_RETRY > 3) begin : g_bad_retry
        $error("MAX_RETRY out of range");
    end

`ifdef RO_SEQ_AUTO_RETRY_EN
    localparam logic [7:0] COOL_LAST = 8'(COOL_CYC - 1);
    localparam logic [1:0] MAX_RC    = 2'(MAX_RETRY);
`endif

    state_t     state;
    logic [7:0] tmr;
    logic [7:0] len_q;
    logic [1:0] retry_cnt;
    logic       run_done;  // FLUSH was entered from a RUN that timed out normally

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tmr       <= '0;
            len_q     <= 8'd1;
            retry_cnt <= '0;
            run_done  <= 1'b0;
        end else begin
            if (tmr != 8'hFF) tmr <= tmr + 8'd1;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.stop) begin
                        state <= PRESS;
                        tmr   <= '0;
                    end
                end
                PRESS: begin
                    if (bus.stop) begin
                        state    <= FLUSH;
                        tmr      <= '0;
                        run_done <= 1'b0;
                    end else if (bus.psi_now >= bus.psi_set) begin
                        state <= RUN;
                        tmr   <= '0;
                        len_q <= (bus.run_len == 8'd0) ? 8'd1 : bus.run_len;
                    end else if (tmr == PRESS_LAST) begin
                        state <= FAULT;
                        tmr   <= '0;
                    end
                end
                RUN: begin
                    // fail_in is stale here; it is only judged at the end of FLUSH
                    if (bus.stop) begin
                        state    <= FLUSH;
                        tmr      <= '0;
                        run_done <= 1'b0;
                    end else if (tmr == len_q - 8'd1) begin
                        state    <= FLUSH;
                        tmr      <= '0;
                        run_done <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (tmr == FLUSH_LAST) begin
                        tmr <= '0;
                        if (bus.fail_in) begin
                            state <= FAULT;
                        end else begin
                            state <= IDLE;
                            if (run_done) retry_cnt <= '0;
                        end
                    end
                end
                FAULT: begin
                    if (bus.clr_fault) begin
                        state     <= IDLE;
                        tmr       <= '0;
                        retry_cnt <= '0;
                    end
`ifdef RO_SEQ_AUTO_RETRY_EN
                    else if (retry_cnt < MAX_RC) begin
                        state <= COOL;
                        tmr   <= '0;
                    end
`endif
                end
                COOL: begin
                    if (bus.clr_fault) begin
                        state     <= IDLE;
                        tmr       <= '0;
                        retry_cnt <= '0;
                    end
`ifdef RO_SEQ_AUTO_RETRY_EN
                    else if (tmr == COOL_LAST) begin
                        state     <= PRESS;
                        tmr       <= '0;
                        retry_cnt <= retry_cnt + 2'd1;
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                    tmr   <= '0;
                end
            endcase
        end
    end

    // Moore decodes of the state register, so reset clears them asynchronously
    assign bus.pump_on     = (state == PRESS) || (state == RUN);
    assign bus.ro_en       = (state == RUN);
    assign bus.valve_flush = (state == FLUSH);
    assign bus.busy        = (state != IDLE);
    assign bus.fault       = (state == FAULT) || (state == COOL);
    assign bus.state       = state;
    assign bus.retry_cnt   = retry_cnt;
endmodule

// File: tb/tb_ro_sequencer.sv
// Scoreboard bench for ro_sequencer: expected states queued per driven cycle, checked after each edge.
module tb_ro_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [1:0] exp_rc = 2'd0;

    typedef struct {
        string      tag;
        logic [2:0] st;
        logic [1:0] rc;
    } exp_t;
    exp_t exp_q[$];

    ro_sequencer_if bus ();

    ro_sequencer #(
        .PRESS_CYC(16),
        .FLUSH_CYC(8),
        .COOL_CYC (32),
        .MAX_RETRY(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("queue_underrun", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk({e.tag, ".state"}, 32'(bus.state), 32'(e.st));
            chk({e.tag, ".pump_on"}, 32'(bus.pump_on), 32'(e.st == 3'd1 || e.st == 3'd2));
            chk({e.tag, ".ro_en"}, 32'(bus.ro_en), 32'(e.st == 3'd2));
            chk({e.tag, ".valve"}, 32'(bus.valve_flush), 32'(e.st == 3'd3));
            chk({e.tag, ".busy"}, 32'(bus.busy), 32'(e.st != 3'd0));
            chk({e.tag, ".fault"}, 32'(bus.fault), 32'(e.st == 3'd4 || e.st == 3'd5));
            chk({e.tag, ".retry"}, 32'(bus.retry_cnt), 32'(e.rc));
        end
    endtask

    task automatic run(input string tag, input logic [2:0] st, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{tag, st, exp_rc});
            step();
        end
    endtask

    initial begin
        bus.start = 0; bus.stop = 0; bus.clr_fault = 0; bus.fail_in = 0;
        bus.psi_now = 0; bus.psi_set = 0; bus.run_len = 0;
        #3;
        chk("reset.state", 32'(bus.state), 32'd0);
        chk("reset.outputs", 32'({bus.pump_on, bus.ro_en, bus.valve_flush, bus.busy, bus.fault}), 32'd0);
        chk("reset.retry", 32'(bus.retry_cnt), 32'd0);
        @(negedge clk);
        rst = 0;
        run("idle", 3'd0, 1);

        // normal cycle: pressure reached on PRESS cycle 3
        bus.psi_set = 50; bus.psi_now = 40; bus.run_len = 10;
        bus.start = 1;
        run("norm_press", 3'd1, 1);
        bus.start = 0;
        run("norm_press", 3'd1, 2);
        bus.psi_now = 60;
        run("norm_run", 3'd2, 10);
        run("norm_flush", 3'd3, 8);
        run("norm_idle", 3'd0, 2);

        // abort during RUN cycle 4
        bus.run_len = 20; bus.start = 1;
        run("abort_press", 3'd1, 1);
        bus.start = 0;
        run("abort_run", 3'd2, 4);
        bus.stop = 1;
        run("abort_flush", 3'd3, 1);
        bus.stop = 0;
        run("abort_flush", 3'd3, 7);
        run("abort_idle", 3'd0, 1);

        // monitor fail rises two cycles into FLUSH
        bus.run_len = 3; bus.start = 1;
        run("mfail_press", 3'd1, 1);
        bus.start = 0;
        run("mfail_run", 3'd2, 3);
        run("mfail_flush", 3'd3, 2);
        bus.fail_in = 1;
        run("mfail_flush", 3'd3, 6);
        run("mfail_fault", 3'd4, 1);
        bus.clr_fault = 1;
        run("mfail_clr", 3'd0, 1);
        bus.clr_fault = 0; bus.fail_in = 0;

        // boundaries: psi_set=0 exits PRESS at once, run_len=0 runs one cycle
        bus.psi_set = 0; bus.psi_now = 0; bus.run_len = 0; bus.start = 1;
        run("bnd_press", 3'd1, 1);
        bus.start = 0;
        run("bnd_run", 3'd2, 1);
        run("bnd_flush", 3'd3, 8);
        run("bnd_idle", 3'd0, 1);
        bus.start = 1; bus.stop = 1;
        run("startstop_idle", 3'd0, 2);
        bus.start = 0; bus.stop = 0;

        // pressure timeout
        bus.psi_set = 50; bus.psi_now = 0; bus.start = 1;
        run("to_press", 3'd1, 1);
        bus.start = 0;
        run("to_press", 3'd1, 15);
`ifdef RO_SEQ_AUTO_RETRY_EN
        run("rt_fault1", 3'd4, 1);
        run("rt_cool1", 3'd5, 32);
        exp_rc = 2'd1;
        run("rt_press1", 3'd1, 16);
        run("rt_fault2", 3'd4, 1);
        run("rt_cool2", 3'd5, 32);
        exp_rc = 2'd2;
        run("rt_press2", 3'd1, 16);
        run("rt_hold", 3'd4, 5);
        bus.clr_fault = 1;
        exp_rc = 2'd0;
        run("rt_clr", 3'd0, 1);
`else
        run("to_fault", 3'd4, 5);
        bus.clr_fault = 1;
        run("to_clr", 3'd0, 1);
`endif
        bus.clr_fault = 0;

        // asynchronous reset mid-RUN
        bus.psi_now = 60; bus.run_len = 20; bus.start = 1;
        run("ar_press", 3'd1, 1);
        bus.start = 0;
        run("ar_run", 3'd2, 3);
        #2 rst = 1;
        #1;
        chk("async_rst.state", 32'(bus.state), 32'd0);
        chk("async_rst.pump_on", 32'(bus.pump_on), 32'd0);
        chk("async_rst.ro_en", 32'(bus.ro_en), 32'd0);
        chk("async_rst.busy", 32'(bus.busy), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        bus.start = 1;
        run("ar_fresh_press", 3'd1, 1);
        bus.start = 0;
        run("ar_fresh_run", 3'd2, 1);
        bus.stop = 1;
        run("ar_fresh_flush", 3'd3, 1);
        bus.stop = 0;
        run("ar_fresh_flush", 3'd3, 7);
        run("ar_fresh_idle", 3'd0, 1);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
